// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
// Optional build macro: MC_CONTROLLER_BNE_EN (adds the BNEEX state).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control word from state only; the *_rdy / *_zero flags are gated by the top.
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       irwrite_rdy;
        logic       pcen_rdy;
        logic       pcen_always;
        logic       pcen_zero;
        logic       pcen_nzero;
    } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational state-to-control-word decode for mc_controller.
// Optional build macro: MC_CONTROLLER_BNE_EN (decodes BNEEX).
module mc_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] st,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (st)
            S_FETCH: begin
                ctrl.alusrcb     = SRCB_FOUR;
                ctrl.aluop       = ALUOP_ADD;
                ctrl.pcsrc       = PCSRC_ALURES;
                ctrl.irwrite_rdy = 1'b1;
                ctrl.pcen_rdy    = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = SRCB_REGB;
                ctrl.aluop     = ALUOP_SUB;
                ctrl.pcsrc     = PCSRC_ALUOUT;
                ctrl.pcen_zero = 1'b1;
            end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_JEX: begin
                ctrl.pcsrc       = PCSRC_JUMP;
                ctrl.pcen_always = 1'b1;
            end
`ifdef MC_CONTROLLER_BNE_EN
            S_BNEEX: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_REGB;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.pcen_nzero = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main control FSM for the MIPS-subset datapath, with memready stalls.
// Optional build macro: MC_CONTROLLER_BNE_EN (adds bne via BNEEX).
//
// state     | meaning
// FETCH     | read instr at PC, PC+4 -> PC, wait for memready
// DECODE    | read regs, precompute branch target, dispatch on op
// MEMADR    | ALU computes lw/sw address
// MEMRD     | data read, wait for memready
// MEMWB     | MDR -> rt
// MEMWR     | data write, wait for memready
// RTYPEEX   | ALU op from funct
// RTYPEWB   | ALUOut -> rd
// BEQEX     | compare, branch when zero
// ADDIEX    | regA + signimm
// ADDIWB    | ALUOut -> rt
// JEX       | jump target -> PC
// BNEEX     | compare, branch when not zero (macro builds only)
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int NSTATEBITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic                  zero,
    input  logic                  memready,
    output logic                  iord,
    output logic                  memwrite,
    output logic                  irwrite,
    output logic                  regdst,
    output logic                  memtoreg,
    output logic                  regwrite,
    output logic                  alusrca,
    output logic [1:0]            alusrcb,
    output logic [1:0]            aluop,
    output logic [1:0]            pcsrc,
    output logic                  pcen,
    output logic                  illegal,
    output logic [NSTATEBITS-1:0] state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = memready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .st   (state_q),
        .ctrl (ctrl)
    );

    assign iord     = ctrl.iord;
    assign memwrite = ctrl.memwrite;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign regwrite = ctrl.regwrite;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign aluop    = ctrl.aluop;
    assign pcsrc    = ctrl.pcsrc;
    assign irwrite  = ctrl.irwrite_rdy & memready;
    assign pcen     = (ctrl.pcen_rdy & memready) | ctrl.pcen_always
                    | (ctrl.pcen_zero & zero) | (ctrl.pcen_nzero & ~zero);
    assign state    = NSTATEBITS'(state_q);

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle main control FSM for the 32-bit MIPS-subset datapath.
- Sequences one shared ALU, one unified instruction/data memory and the register file across several cycles per instruction.
- Drives the datapath mux selects, write enables and the 2-bit aluop. The existing ALU decoder turns aluop plus funct into alucontrol.
- Stalls on a memory-ready handshake so slow memory can be attached.

Parameters:
- NSTATEBITS, 4, width of the state register (13 codes max used).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  opcode field of the instruction register (instr[31:26]).
- zero  in  1  ALU zero flag from the current cycle.
- memready  in  1  memory completes access this cycle.
- iord  out  1  memory address select (0 = PC, 1 = ALUOut).
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regdst  out  1  write register select (1 = rd, 0 = rt).
- memtoreg  out  1  write-back data select (1 = MDR).
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select (0 = PC, 1 = regA).
- alusrcb  out  2  ALU B select (00 regB, 01 const 4, 10 signimm, 11 signimm<<2).
- aluop  out  2  to ALU decoder (00 add, 01 sub, 10 funct).
- pcsrc  out  2  next-PC select (00 ALUResult, 01 ALUOut, 10 jump target).
- pcen  out  1  PC write enable.
- illegal  out  1  one-cycle pulse, unknown opcode seen in DECODE.
- state  out  NSTATEBITS  current state, for debug/trace.

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12 (macro only).
- Reset: when reset=1 at posedge, state becomes FETCH. Reset overrides any in-flight instruction, including mid-memory-stall.
- Output decoding:
  - All outputs are combinational from state. pcen and irwrite additionally use zero or memready.
  - Any output not listed for a state is 0.
  - During and just after reset, outputs equal the FETCH values.
- Transitions and per-state outputs:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=memready, pcen=memready. Holds in FETCH while memready=0; goes to DECODE when memready=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target precomputed). Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - any other opcode -> FETCH with illegal=1 for this cycle
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Holds until memready=1, then MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
  - MEMWR: iord=1, memwrite=1, held asserted until memready=1, then FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10, then RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero, then FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00, then ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
  - JEX: pcsrc=10, pcen=1, then FETCH.
- Latency with memready tied to 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3. Each memready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Unused state codes (13-15) go to FETCH on the next edge with all outputs 0.
- regwrite and memwrite are never both 1. pcen is never 1 outside FETCH, BEQEX, JEX and BNEEX.

Optional Feature:
- Macro: MC_CONTROLLER_BNE_EN.
- Defined:
  - op 000101 in DECODE goes to BNEEX.
  - BNEEX drives the same outputs as BEQEX except pcen=~zero, then FETCH.
- Undefined:
  - op 000101 is illegal: DECODE goes to FETCH and illegal pulses.
  - State code 12 is treated as an unused code.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum typedef (logic [3:0]);
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - aluop constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - alusrcb and pcsrc select constants.
- Sub-module mc_outdec: purely combinational state-to-control-word decode. mc_controller keeps the state register, next-state logic and the memready/zero gating.

Test Plan:
- reset=1 for 2 cycles with op=100011 -> state=0; iord=0, alusrcb=01, pcen=1 with memready=1; no regwrite or memwrite.
- lw (op=100011), memready=1 -> states 0,1,2,3,4,0; regwrite=1 with memtoreg=1 only in the 5th cycle.
- sw with memready=0 for 3 cycles in MEMWR -> memwrite=1 held 4 cycles; FETCH follows the cycle memready=1.
- beq with zero=1 -> pcen=1 and pcsrc=01 in BEQEX. Repeat with zero=0 -> pcen=0, next state FETCH.
- op=111111 -> DECODE goes to FETCH, illegal=1 for exactly one cycle, no write enables.
- Assert reset mid-MEMRD stall -> state=FETCH next edge, iord=0. With MC_CONTROLLER_BNE_EN: op=000101, zero=0 -> pcen=1 in state 12.
